icache: RTL and testbench

Direct-mapped, read-only instruction cache: the responder end of the fetch stage's instruction request path. It takes the datapath's instruction read request (`imemREN`/`imemaddr`) and answers with `ihit`/`imemload`, which the fetch stage consumes as its `ihit` and `cache_in` inputs. On a miss it fills one word from the memory controller through a single-outstanding `iREN`/`iwait` handshake. It sits between the fetch stage and the memory arbiter/controller.

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_if.sv | 26 ++
 rtl/icache_frame_array.sv | 47 ++++
 rtl/icache.sv | 104 ++++++++++
 tb/tb_icache.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned ICACHE_SETS = 16;
    localparam int unsigned ICACHE_IDX  = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAGW = 30 - ICACHE_IDX;

    // Address split for the default geometry.
    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDX-1:0]  idx;
        logic [1:0]             bytoff;
    } icachef_t;

    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
        word_t                  data;
    } icache_frame_t;

    // FSM encoding kept as plain constants for older tool flows.
    typedef logic icache_state_t;
    localparam icache_state_t IDLE = 1'b0;
    localparam icache_state_t FILL = 1'b1;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side request/response and memory-side fill handshake of the icache.
interface icache_if;
    import icache_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    // Cache side.
    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    // Fetch stage plus memory controller side.
    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_frame_array.sv
// Frame storage: one combinational read port, one synchronous write port.
// Only the valid bits are reset; tag/data are qualified by valid.
module icache_frame_array
    import icache_pkg::*;
#(
    parameter int unsigned SETS = ICACHE_SETS,
    parameter int unsigned IDX  = $clog2(SETS),
    parameter int unsigned TAGW = 30 - IDX
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [IDX-1:0]  rd_idx,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output word_t           rd_data,
    input  logic            wr_en,
    input  logic [IDX-1:0]  wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  word_t           wr_data
);

    logic [SETS-1:0] valid_q;
    logic [TAGW-1:0] tag_q  [SETS];
    word_t           data_q [SETS];

    // Valid bits: cleared by reset, set by a completed fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload written on fill completion.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word miss fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    icache_if.slave     cif
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAGW = 30 - IDX;

    icache_state_t   state_q, state_d;
    word_t           miss_addr_q, miss_addr_d;

    logic [IDX-1:0]  req_idx;
    logic [TAGW-1:0] req_tag;
    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    word_t           rd_data;
    logic            lookup_hit;
    logic            start_fill;
    logic            fill_done;
    logic            unused_byte_off;

    assign req_idx         = cif.imemaddr[IDX+1:2];
    assign req_tag         = cif.imemaddr[31:IDX+2];
    assign unused_byte_off = ^cif.imemaddr[1:0];

    icache_frame_array #(
        .SETS (SETS),
        .IDX  (IDX),
        .TAGW (TAGW)
    ) u_frames (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_done),
        .wr_idx   (miss_addr_q[IDX+1:2]),
        .wr_tag   (miss_addr_q[31:IDX+2]),
        .wr_data  (cif.iload)
    );

    // Lookup, handshake outputs and next-state decode.
    always_comb begin
        lookup_hit   = cif.imemREN & rd_valid & (rd_tag == req_tag);
        start_fill   = (state_q == IDLE) & cif.imemREN & ~lookup_hit;
        fill_done    = (state_q == FILL) & ~cif.iwait;
        cif.ihit     = (state_q == IDLE) & lookup_hit;
        // Invalid frames read as zero so nothing uninitialised leaves the cache.
        cif.imemload = rd_valid ? rd_data : '0;
        cif.iREN     = (state_q == FILL);
        cif.iaddr    = (state_q == FILL) ? miss_addr_q : '0;

        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        if (start_fill) begin
            state_d     = FILL;
            miss_addr_d = word_align(cif.imemaddr);
        end else if (fill_done) begin
            state_d = IDLE;
        end
    end

    // FSM state and latched miss address; reset abandons any pending fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

`ifdef ICACHE_STATS_EN
    // Free-running wrap-around hit and miss counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (cif.ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
module tb_icache;
    import icache_pkg::*;

    logic clk;
    logic nrst;
    int   tests;
    int   failed;

    icache_if cif ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(
        .SETS (16)
    ) dut (
        .CLK        (clk),
        .nRST       (nrst),
        .cif        (cif)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic ren, input word_t addr, input logic wt, input word_t ld);
        @(negedge clk);
        cif.imemREN  = ren;
        cif.imemaddr = addr;
        cif.iwait    = wt;
        cif.iload    = ld;
        #1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        nrst   = 1'b0;
        cif.imemREN  = 1'b0;
        cif.imemaddr = 32'h0;
        cif.iwait    = 1'b1;
        cif.iload    = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ihit", {31'b0, cif.ihit}, 32'd0);
        check("rst_iren", {31'b0, cif.iREN}, 32'd0);
        check("rst_iaddr", cif.iaddr, 32'h0);
        check("rst_imemload", cif.imemload, 32'h0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        @(negedge clk);
        nrst = 1'b1;

        // Miss on 0x40 with 3 wait cycles
        drive(1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
        check("m40_c0_ihit", {31'b0, cif.ihit}, 32'd0);
        check("m40_c0_iren", {31'b0, cif.iREN}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40, (i == 3) ? 1'b0 : 1'b1,
                  (i == 3) ? 32'h8C22_0004 : 32'hDEAD_BEEF);
            check("m40_fill_iren", {31'b0, cif.iREN}, 32'd1);
            check("m40_fill_iaddr", cif.iaddr, 32'h40);
            check("m40_fill_ihit", {31'b0, cif.ihit}, 32'd0);
        end
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        check("m40_post_ihit", {31'b0, cif.ihit}, 32'd1);
        check("m40_post_data", cif.imemload, 32'h8C22_0004);
        check("m40_post_iren", {31'b0, cif.iREN}, 32'd0);

        // Re-request hits in the same cycle, byte offset ignored
        drive(1'b1, 32'h43, 1'b1, 32'h0);
        check("h40_ihit", {31'b0, cif.ihit}, 32'd1);
        check("h40_data", cif.imemload, 32'h8C22_0004);
        check("h40_iren", {31'b0, cif.iREN}, 32'd0);
        drive(1'b0, 32'h40, 1'b1, 32'h0);
        check("noren_ihit", {31'b0, cif.ihit}, 32'd0);

        // 0x80 shares index 0: refill, then 0x40 misses again
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        check("m80_ihit", {31'b0, cif.ihit}, 32'd0);
        drive(1'b1, 32'h80, 1'b0, 32'h0000_0000);
        check("m80_iren", {31'b0, cif.iREN}, 32'd1);
        check("m80_iaddr", cif.iaddr, 32'h80);
        drive(1'b1, 32'h80, 1'b1, 32'h0);
        check("h80_ihit", {31'b0, cif.ihit}, 32'd1);
        check("h80_data", cif.imemload, 32'h0);
        drive(1'b1, 32'h40, 1'b1, 32'h0);
        check("evict40_ihit", {31'b0, cif.ihit}, 32'd0);
        drive(1'b1, 32'h40, 1'b0, 32'h8C22_0004);
        check("refill40_iaddr", cif.iaddr, 32'h40);
        drive(1'b0, 32'h0, 1'b1, 32'h0);

        // Redirect mid-fill: 0x100 still completes, then 0x44 fills
        drive(1'b1, 32'h100, 1'b1, 32'h0);
        check("m100_ihit", {31'b0, cif.ihit}, 32'd0);
        drive(1'b1, 32'h44, 1'b1, 32'h0);
        check("redir_iaddr", cif.iaddr, 32'h100);
        check("redir_ihit", {31'b0, cif.ihit}, 32'd0);
        drive(1'b1, 32'h44, 1'b0, 32'h1111_2222);
        check("redir_iren", {31'b0, cif.iREN}, 32'd1);
        check("redir_iaddr2", cif.iaddr, 32'h100);
        drive(1'b1, 32'h44, 1'b1, 32'h0);
        check("m44_ihit", {31'b0, cif.ihit}, 32'd0);
        check("m44_iren", {31'b0, cif.iREN}, 32'd0);
        drive(1'b1, 32'h44, 1'b0, 32'h3333_4444);
        check("m44_iaddr", cif.iaddr, 32'h44);
        drive(1'b1, 32'h100, 1'b1, 32'h0);
        check("h100_ihit", {31'b0, cif.ihit}, 32'd1);
        check("h100_data", cif.imemload, 32'h1111_2222);
        drive(1'b1, 32'h44, 1'b1, 32'h0);
        check("h44_ihit", {31'b0, cif.ihit}, 32'd1);
        check("h44_data", cif.imemload, 32'h3333_4444);

        // Reset during FILL abandons the fill
        drive(1'b1, 32'h200, 1'b1, 32'h0);
        check("m200_ihit", {31'b0, cif.ihit}, 32'd0);
        drive(1'b1, 32'h200, 1'b1, 32'h0);
        check("m200_iren", {31'b0, cif.iREN}, 32'd1);
        check("m200_iaddr", cif.iaddr, 32'h200);
        #1;
        nrst = 1'b0;
        #1;
        check("rstfill_iren", {31'b0, cif.iREN}, 32'd0);
        check("rstfill_iaddr", cif.iaddr, 32'h0);
        check("rstfill_ihit", {31'b0, cif.ihit}, 32'd0);
        cif.iwait = 1'b0;
        cif.iload = 32'hBAD0_BAD0;
        @(negedge clk);
        nrst = 1'b1;

        // Pending address misses after release; 1 miss then 6 hit cycles
        drive(1'b1, 32'h200, 1'b1, 32'h0);
        check("post_rst_ihit", {31'b0, cif.ihit}, 32'd0);
        check("post_rst_data", cif.imemload, 32'h0);
`ifdef ICACHE_STATS_EN
        check("post_rst_hit_count", hit_count, 32'd0);
        check("post_rst_miss_count", miss_count, 32'd0);
`endif
        drive(1'b1, 32'h200, 1'b0, 32'hA5A5_0200);
        check("f200_iren", {31'b0, cif.iREN}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h200, 1'b1, 32'h0);
            check("h200_ihit", {31'b0, cif.ihit}, 32'd1);
            check("h200_data", cif.imemload, 32'hA5A5_0200);
        end
        drive(1'b0, 32'h0, 1'b1, 32'h0);
`ifdef ICACHE_STATS_EN
        check("stats_miss_count", miss_count, 32'd1);
        check("stats_hit_count", hit_count, 32'd6);
`endif
        check("idle_iren", {31'b0, cif.iREN}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
